// File: rtl/haraka_stream_pkg.sv
// Shared definitions for the Haraka-S lane/word stream blocks (serializer and
// deserializer). Holds the default geometry, the derived lane count and the
// lane-index / lane-count types for that default geometry, plus a width helper
// for parameterised instances.
package haraka_stream_pkg;

    localparam int unsigned DEF_WORDWIDTH = 256;
    localparam int unsigned DEF_LANEWIDTH = 8;
    localparam int unsigned DEF_LANES     = DEF_WORDWIDTH / DEF_LANEWIDTH;

    // Lane index 0..LANES-1, and lane count 1..LANES (one bit wider).
    typedef logic [$clog2(DEF_LANES)-1:0] lane_idx_t;
    typedef logic [$clog2(DEF_LANES):0]   lane_len_t;

    // Index width for an arbitrary lane count; a single-lane word still needs
    // a one-bit index register.
    function automatic int unsigned idx_width(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/word_hold_reg.sv
// Single-entry output holding register with valid/ready handshake.
// A load in the same cycle as a drain replaces the word without a bubble.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   load_i             capture word_i/len_i/last_i this cycle
//   word_i/len_i/last_i fields to capture
//   ready_i            consumer accepts the held word this cycle
//   valid_o            holder is full
//   word_o/len_o/last_o held fields (don't-care while valid_o=0)
module word_hold_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LENW  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic [LENW-1:0]  len_i,
    input  logic             last_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] word_o,
    output logic [LENW-1:0]  len_o,
    output logic             last_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [LENW-1:0]  len_q, len_d;
    logic             last_q, last_d;

    always_comb begin
        valid_d = valid_q;
        word_d  = word_q;
        len_d   = len_q;
        last_d  = last_q;
        if (load_i) begin
            valid_d = 1'b1;
            word_d  = word_i;
            len_d   = len_i;
            last_d  = last_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            word_q  <= '0;
            len_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
            len_q   <= len_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign word_o  = word_q;
    assign len_o   = len_q;
    assign last_o  = last_q;

endmodule

// File: rtl/deserializer.sv
// Packs a narrow lane stream into full-width words for the Haraka-S absorb
// datapath, reporting the number of valid lanes and the end of message.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   in_data/in_valid/in_last/in_ready   lane input handshake
//   out_word        packed word, lane 0 in the least significant bits
//   out_length      valid lanes in out_word (1..LANES)
//   out_last        word ends the message
//   out_valid/out_ready                 word output handshake
module deserializer
    import haraka_stream_pkg::*;
#(
    parameter int unsigned WORDWIDTH = DEF_WORDWIDTH,
    parameter int unsigned LANEWIDTH = DEF_LANEWIDTH
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [LANEWIDTH-1:0]                  in_data,
    input  logic                                  in_valid,
    input  logic                                  in_last,
    output logic                                  in_ready,
    output logic [WORDWIDTH-1:0]                  out_word,
    output logic [$clog2(WORDWIDTH/LANEWIDTH):0]  out_length,
    output logic                                  out_last,
    output logic                                  out_valid,
    input  logic                                  out_ready
);

    localparam int unsigned LANES = WORDWIDTH / LANEWIDTH;
    localparam int unsigned IDXW  = idx_width(LANES);
    localparam int unsigned LENW  = $clog2(LANES) + 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LANES - 1);

    if (LANEWIDTH == 0 || (WORDWIDTH % LANEWIDTH) != 0) begin : g_bad_geometry
        $error("deserializer: WORDWIDTH must be an integer multiple of LANEWIDTH");
    end

    typedef enum logic {
        EMPTY,
        FILLING
    } state_e;

    state_e               state_q, state_d;
    logic [WORDWIDTH-1:0] acc_q, acc_d;
    logic [IDXW-1:0]      idx_q, idx_d;

    logic                 accept;
    logic                 publish;
    logic [WORDWIDTH-1:0] pub_word;
    logic [LENW-1:0]      pub_len;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        if (accept) begin
            if (publish) begin
                state_d = EMPTY;
                acc_d   = '0;
                idx_d   = '0;
            end else begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    if (idx_q == IDXW'(i)) acc_d[i*LANEWIDTH +: LANEWIDTH] = in_data;
                end
                idx_d   = idx_q + IDXW'(1);
                state_d = FILLING;
            end
        end
    end

    // Output / handshake logic. Lanes above idx are already zero in acc
    // (cleared on publish and reset, filled in order), so inserting the
    // current lane yields the zero-padded word directly.
    always_comb begin
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
        publish  = accept && (in_last || idx_q == LAST_IDX);
        pub_word = acc_q;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (idx_q == IDXW'(i)) pub_word[i*LANEWIDTH +: LANEWIDTH] = in_data;
        end
        pub_len  = LENW'(idx_q) + LENW'(1);
    end

    word_hold_reg #(
        .WIDTH (WORDWIDTH),
        .LENW  (LENW)
    ) u_hold (
        .clk     (clk),
        .reset   (reset),
        .load_i  (publish),
        .word_i  (pub_word),
        .len_i   (pub_len),
        .last_i  (in_last),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .word_o  (out_word),
        .len_o   (out_length),
        .last_o  (out_last)
    );

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for the deserializer: a 32/8 instance for the main tests
// and a 256/8 instance for the default geometry.
module tb_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid, in_last, in_ready;
    logic [31:0] out_word;
    logic [2:0]  out_length;
    logic        out_last, out_valid, out_ready;

    logic [7:0]   b_data;
    logic         b_valid, b_last, b_ready;
    logic [255:0] b_word;
    logic [5:0]   b_length;
    logic         b_last_o, b_valid_o, b_out_ready;

    deserializer #(.WORDWIDTH(32), .LANEWIDTH(8)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_word   (out_word),
        .out_length (out_length),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    deserializer #(.WORDWIDTH(256), .LANEWIDTH(8)) u_big (
        .clk        (clk),
        .reset      (reset),
        .in_data    (b_data),
        .in_valid   (b_valid),
        .in_last    (b_last),
        .in_ready   (b_ready),
        .out_word   (b_word),
        .out_length (b_length),
        .out_last   (b_last_o),
        .out_valid  (b_valid_o),
        .out_ready  (b_out_ready)
    );

    typedef struct packed {
        logic [31:0] word;
        logic [2:0]  len;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic fail(input string name, input string what);
        n_total++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Monitor: a word is consumed at the next posedge when valid && ready.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                fail("unexpected_word", $sformatf("got word %08h len %0d, required no word", out_word, out_length));
            end else begin
                e = sb.pop_front();
                check("word",   256'(out_word),   256'(e.word));
                check("length", 256'(out_length), 256'(e.len));
                check("last",   256'(out_last),   256'(e.last));
            end
        end
    end

    // Reference packer, enabled only for the random traffic section.
    bit          model_en = 1'b0;
    logic [31:0] m_acc    = '0;
    int unsigned m_idx    = 0;
    always @(negedge clk) begin
        if (model_en && !reset && in_valid && in_ready) begin
            m_acc[m_idx*8 +: 8] = in_data;
            if (m_idx == 3 || in_last) begin
                sb.push_back('{word: m_acc, len: 3'(m_idx + 1), last: in_last});
                m_acc = '0;
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        for (int c = 0; ; c++) begin
            @(negedge clk);
            if (in_ready) break;
            if (c >= 200) begin
                fail("send_timeout", "got in_ready=0 for 200 cycles, required 1");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [255:0] big_exp;
        int unsigned  accepted;
        int           cycles;
        bit           got;

        reset = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        b_data = '0; b_valid = 1'b0; b_last = 1'b0; b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid",  256'(out_valid),  256'(0));
        check("rst_out_word",   256'(out_word),   256'(0));
        check("rst_out_length", 256'(out_length), 256'(0));
        check("rst_out_last",   256'(out_last),   256'(0));
        check("rst_in_ready",   256'(in_ready),   256'(1));
        @(posedge clk); #1;

        // Full word ending the message; valid must be a single-cycle pulse
        sb.push_back('{32'h44332211, 3'd4, 1'b1});
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("full_valid", 256'(out_valid), 256'(1));
        @(negedge clk);
        check("full_pulse", 256'(out_valid), 256'(0));
        @(posedge clk); #1;

        // Partial last word, upper lanes zero
        sb.push_back('{32'h0000BBAA, 3'd2, 1'b1});
        send(8'hAA, 1'b0); send(8'hBB, 1'b1);
        idle(2);

        // Multi-word message, last not on a boundary; starts from a cleared acc
        sb.push_back('{32'h04030201, 3'd4, 1'b0});
        sb.push_back('{32'h00000605, 3'd2, 1'b1});
        for (int i = 1; i <= 6; i++) send(8'(i), i == 6);
        idle(3);

        // Backpressure with continuous input, then zero-bubble release
        out_ready = 1'b0;
        sb.push_back('{32'h14131211, 3'd4, 1'b0});
        sb.push_back('{32'h18171615, 3'd4, 1'b1});
        send(8'h11, 1'b0); send(8'h12, 1'b0); send(8'h13, 1'b0); send(8'h14, 1'b0);
        in_data = 8'h15; in_last = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready",  256'(in_ready),   256'(0));
            check("bp_out_valid", 256'(out_valid),  256'(1));
            check("bp_word",      256'(out_word),   256'(32'h14131211));
            check("bp_length",    256'(out_length), 256'(4));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 256'(in_ready), 256'(1));
        @(posedge clk); #1;
        send(8'h16, 1'b0); send(8'h17, 1'b0); send(8'h18, 1'b1);
        idle(3);

        // Random valid/ready traffic against the reference packer
        model_en = 1'b1;
        accepted = 0;
        cycles   = 0;
        while (accepted < 100 && cycles < 3000) begin
            out_ready = ($urandom % 3) != 0;
            in_valid  = ($urandom % 4) != 0;
            in_data   = 8'($urandom);
            in_last   = (accepted == 99) ? 1'b1 : (($urandom % 6) == 0);
            @(negedge clk);
            if (in_valid && in_ready) accepted++;
            @(posedge clk); #1;
            cycles++;
        end
        if (accepted < 100) fail("random_timeout", $sformatf("got %0d accepted lanes, required 100", accepted));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        model_en  = 1'b0;
        idle(4);

        // Reset mid-word drops the partial word
        send(8'hDE, 1'b0); send(8'hAD, 1'b0); send(8'hBE, 1'b0);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_out_valid", 256'(out_valid), 256'(0));
        check("rstmid_in_ready",  256'(in_ready),  256'(1));
        @(posedge clk); #1;
        sb.push_back('{32'h00000B0A, 3'd2, 1'b1});
        send(8'h0A, 1'b0); send(8'h0B, 1'b1);
        idle(3);

        // Reset while a word is held drops it
        out_ready = 1'b0;
        send(8'h55, 1'b0); send(8'h66, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("held_out_valid", 256'(out_valid), 256'(1));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rsthold_out_valid",  256'(out_valid),  256'(0));
        check("rsthold_out_word",   256'(out_word),   256'(0));
        check("rsthold_out_length", 256'(out_length), 256'(0));
        check("rsthold_out_last",   256'(out_last),   256'(0));
        check("rsthold_in_ready",   256'(in_ready),   256'(1));
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(3);

        // Default geometry: 32 lanes 0x00..0x1F
        big_exp = '0;
        for (int i = 0; i < 32; i++) big_exp[i*8 +: 8] = 8'(i);
        for (int i = 0; i < 32; i++) begin
            b_data  = 8'(i);
            b_last  = (i == 31);
            b_valid = 1'b1;
            @(negedge clk);
            if (!b_ready) fail("big_in_ready", "got 0, required 1");
            @(posedge clk); #1;
        end
        b_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (b_valid_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            fail("big_timeout", "got out_valid=0 for 5 cycles, required 1");
        end else begin
            check("big_length",  256'(b_length),      256'(32));
            check("big_lane0",   256'(b_word[7:0]),   256'(8'h00));
            check("big_lane31",  256'(b_word[255:248]), 256'(8'h1F));
            check("big_word",    b_word,              big_exp);
            check("big_last",    256'(b_last_o),      256'(1));
        end
        @(posedge clk); #1;

        // Everything expected must have been observed
        for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
        check("scoreboard_empty", 256'(sb.size()), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
